fetch_unit: RTL and testbench

- Instruction fetch stage of the pipelined MIPS core.
- Owns the PC and issues requests to instruction memory over a req/valid handshake.
- Drives the IF/ID pipeline register, whose opcode field feeds the Control decoder.
- Handles memory wait states, downstream stalls, branch redirects and flushes.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    CANCEL = 2'd2,
    DRAIN  = 2'd3
  } fetch_state_t;

  localparam int          OP_MSB   = 31;
  localparam int          OP_LSB   = 26;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {pc, instr} holding buffer for a word fetched while IF/ID is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        put,
  input  logic        take,
  input  logic        clear,
  input  logic [31:0] put_pc,
  input  logic [31:0] put_instr,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // clear wins over put so a redirect never leaves a stale word behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_WORD;
    end else if (clear) begin
      full <= 1'b0;
    end else if (put) begin
      full  <= 1'b1;
      pc    <= put_pc;
      instr <= put_instr;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: PC, imem req/valid handshake and the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  // Handshake: a request completes on a rising edge where imem_req_o and
  // imem_valid_i are both high; imem_addr_o is held until then.
  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  instr_q;
  logic [31:0]  target;
  logic [31:0]  pc_seq;
  logic         resp;
  logic         can_accept;
  logic         skid_put;
  logic         skid_take;
  logic         skid_full;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;
  logic         load_mem;
  logic         load_any;
  logic [31:0]  load_pc;
  logic [31:0]  load_instr;

  assign resp       = imem_req_o & imem_valid_i;
  assign can_accept = ~stall_i | ~valid_o;
  assign target     = align_word(branch_addr_i);
  assign pc_seq     = pc + PC_STEP;

  assign load_mem   = (state == REQ) & resp & ~branch_i & can_accept;
  assign skid_put   = (state == REQ) & resp & ~branch_i & ~can_accept;
  assign skid_take  = (state == DRAIN) & skid_full & ~branch_i & ~stall_i;
  assign load_any   = load_mem | skid_take;
  assign load_pc    = skid_take ? skid_pc : pc;
  assign load_instr = skid_take ? skid_instr : imem_data_i;

  fetch_skid_buf u_skid (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .put       (skid_put),
    .take      (skid_take),
    .clear     (branch_i),
    .put_pc    (pc),
    .put_instr (imem_data_i),
    .full      (skid_full),
    .pc        (skid_pc),
    .instr     (skid_instr)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state       <= REQ;
          imem_req_o  <= 1'b1;
          pc          <= branch_i ? target : pc;
          imem_addr_o <= branch_i ? target : pc;
        end
        REQ: begin
          if (branch_i) begin
            pc <= target;
            if (resp) imem_addr_o <= target;
            else      state       <= CANCEL;
          end else if (resp) begin
            pc <= pc_seq;
            if (can_accept) begin
              imem_addr_o <= pc_seq;
            end else begin
              state      <= DRAIN;
              imem_req_o <= 1'b0;
            end
          end
        end
        // old address stays on the bus until its response arrives and is dropped
        CANCEL: begin
          if (branch_i) pc <= target;
          if (resp) begin
            state       <= REQ;
            imem_addr_o <= branch_i ? target : pc;
          end
        end
        DRAIN: begin
          if (branch_i) begin
            pc          <= target;
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= target;
          end else if (!stall_i) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc;
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register; an unstalled cycle without a load leaves a bubble
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_o       <= RESET_PC;
      pc_plus4_o <= RESET_PC + PC_STEP;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_any) begin
      valid_o    <= 1'b1;
      instr_q    <= load_instr;
      pc_o       <= load_pc;
      pc_plus4_o <= load_pc + PC_STEP;
    end else if (!stall_i) begin
      valid_o <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign instr_o = instr_q;
  assign op_o    = instr_q[OP_MSB:OP_LSB];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_o <= 32'h0;
      stall_cnt_o <= 32'h0;
    end else begin
      if (load_any && !flush_i && fetch_cnt_o != 32'hFFFF_FFFF)
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (valid_o && stall_i && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a wait-state instruction memory responder.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic [5:0]  op_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int total = 0;
  int bad = 0;
  int waits = 0;
  int wcnt = 0;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_valid_i  (imem_valid_i),
    .imem_data_i   (imem_data_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_o       (instr_o),
    .op_o          (op_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8) ? 32'h8C01_0004 : a;
  endfunction

  // memory: answers the current request after 'waits' idle cycles
  always @(posedge clk_i) begin
    #1;
    if (!rst_i) begin
      imem_valid_i = 1'b0;
      wcnt = 0;
    end else begin
      if (imem_valid_i) wcnt = 0;
      if (imem_req_o && wcnt >= waits) begin
        imem_valid_i = 1'b1;
        imem_data_i  = mem_word(imem_addr_o);
      end else begin
        imem_valid_i = 1'b0;
        if (imem_req_o) wcnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int w);
    waits    = w;
    rst_i    = 1'b0;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    branch_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a, input int max);
    int n = 0;
    while (!(imem_req_o && imem_addr_o == a) && n < max) begin
      step();
      n++;
    end
    check("wait_addr", imem_addr_o, a);
  endtask

  initial begin
    // reset values
    waits = 0;
    step();
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_op", {26'h0, op_o}, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pc4", pc_plus4_o, 32'h4);
    check("rst_req", {31'h0, imem_req_o}, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);

    // zero-wait back-to-back fetch
    do_reset(0);
    step();
    check("zw_req", {31'h0, imem_req_o}, 32'h1);
    check("zw_addr0", imem_addr_o, 32'h0);
    check("zw_valid0", {31'h0, valid_o}, 32'h0);
    step();
    check("zw_addr4", imem_addr_o, 32'h4);
    check("zw_pc0", pc_o, 32'h0);
    check("zw_pc4_0", pc_plus4_o, 32'h4);
    check("zw_valid1", {31'h0, valid_o}, 32'h1);
    step();
    check("zw_addr8", imem_addr_o, 32'h8);
    check("zw_pc4", pc_o, 32'h4);
    check("zw_instr4", instr_o, 32'h4);
    step();
    check("zw_pc8", pc_o, 32'h8);

    // two wait states
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws_valid_lo", {31'h0, valid_o}, 32'h0);
    end
    step();
    check("ws_pc0", pc_o, 32'h0);
    check("ws_v0", {31'h0, valid_o}, 32'h1);
    check("ws_addr4a", imem_addr_o, 32'h4);
    step();
    check("ws_addr4b", imem_addr_o, 32'h4);
    check("ws_gap1", {31'h0, valid_o}, 32'h0);
    step();
    check("ws_addr4c", imem_addr_o, 32'h4);
    check("ws_gap2", {31'h0, valid_o}, 32'h0);
    step();
    check("ws_pc4", pc_o, 32'h4);
    check("ws_v4", {31'h0, valid_o}, 32'h1);
    check("ws_addr8", imem_addr_o, 32'h8);
    step();
    step();
    check("ws_gap3", {31'h0, valid_o}, 32'h0);
    step();
    check("ws_pc8", pc_o, 32'h8);

    // stall while 8C01_0004 returns: parked in the skid buffer
    do_reset(0);
    step();
    step();
    step();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sk_hold_pc", pc_o, 32'h4);
      check("sk_hold_instr", instr_o, 32'h4);
      check("sk_req_lo", {31'h0, imem_req_o}, 32'h0);
    end
    stall_i = 1'b0;
    step();
    check("sk_op", {26'h0, op_o}, 32'h23);
    check("sk_instr", instr_o, 32'h8C01_0004);
    check("sk_pc", pc_o, 32'h8);
    check("sk_pc4", pc_plus4_o, 32'hC);
    check("sk_next_addr", imem_addr_o, 32'hC);
    step();
    check("sk_pc_c", pc_o, 32'hC);
    step();
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", fetch_cnt_o, 32'd5);
    check("perf_stall", stall_cnt_o, 32'd3);
`endif

    // branch during a two-wait-state request to 0x10
    do_reset(2);
    wait_addr(32'h10, 40);
    branch_i = 1'b1;
    branch_addr_i = 32'h0000_0103;
    step();
    branch_i = 1'b0;
    check("br_old_addr", imem_addr_o, 32'h10);
    check("br_req", {31'h0, imem_req_o}, 32'h1);
    check("br_v14", {31'h0, valid_o}, 32'h0);
    step();
    check("br_old_addr2", imem_addr_o, 32'h10);
    check("br_v15", {31'h0, valid_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("br_new_addr", imem_addr_o, 32'h100);
      check("br_no_old", {31'h0, valid_o}, 32'h0);
    end
    step();
    check("br_pc", pc_o, 32'h100);
    check("br_instr", instr_o, 32'h100);

    // flush with stall, then flush with same-cycle response and branch
    do_reset(0);
    step();
    step();
    step();
    flush_i = 1'b1;
    stall_i = 1'b1;
    step();
    flush_i = 1'b0;
    stall_i = 1'b0;
    check("fl_valid", {31'h0, valid_o}, 32'h0);
    check("fl_op", {26'h0, op_o}, 32'h0);
    check("fl_instr", instr_o, 32'h0);
    step();
    check("fl_skid_pc", pc_o, 32'h8);
    check("fl_skid_v", {31'h0, valid_o}, 32'h1);
    flush_i = 1'b1;
    branch_i = 1'b1;
    branch_addr_i = 32'h0000_0200;
    step();
    flush_i = 1'b0;
    branch_i = 1'b0;
    check("flb_valid", {31'h0, valid_o}, 32'h0);
    check("flb_addr", imem_addr_o, 32'h200);
    step();
    check("flb_pc", pc_o, 32'h200);
    check("flb_v", {31'h0, valid_o}, 32'h1);

    // PC wrap at the top of the address space, low bits of target ignored
    do_reset(0);
    step();
    step();
    branch_i = 1'b1;
    branch_addr_i = 32'hFFFF_FFFF;
    step();
    branch_i = 1'b0;
    check("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
    check("wr_bubble", {31'h0, valid_o}, 32'h0);
    step();
    check("wr_next_addr", imem_addr_o, 32'h0);
    check("wr_pc", pc_o, 32'hFFFF_FFFC);
    check("wr_pc4", pc_plus4_o, 32'h0);
    step();
    check("wr_pc0", pc_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
